// File: rtl/master_output_drain_control_pkg.sv
// ---------------------------------------------------------------------------
// master_output_drain_control_pkg
// Shared definitions for the output drain master.
//   drain_state_e : FSM encoding (IDLE -> DRAIN -> DONE -> IDLE)
//   col_slice_lo  : low bit of a column's slice in a packed per-column bus;
//                   the weight fill master uses the same packing.
// ---------------------------------------------------------------------------
package master_output_drain_control_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } drain_state_e;

  // Column c occupies bits [c*width +: width] of a packed per-column bus.
  function automatic int col_slice_lo(input int col, input int width);
    return col * width;
  endfunction

endpackage

// File: rtl/master_output_drain_control_if.sv
// ---------------------------------------------------------------------------
// master_output_drain_control_if
// Job handshake plus output-memory write bus of the drain master.
//   start / num_row / num_col / base_addr : job request and descriptor
//   outMem_wr_en   : per-column write enable, bit c = column c
//   outMem_wr_addr : per-column address, [c*ADDR_WIDTH +: ADDR_WIDTH]
//   active / done  : job status
// modport master : the drain controller; modport slave : its user.
// ---------------------------------------------------------------------------
interface master_output_drain_control_if #(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8
);
  localparam int ROW_W = $clog2(SYS_ARR_ROWS);
  localparam int COL_W = $clog2(SYS_ARR_COLS);

  logic                               start;
  logic [ROW_W-1:0]                   num_row;
  logic [COL_W-1:0]                   num_col;
  logic [ADDR_WIDTH-1:0]              base_addr;
  logic [SYS_ARR_COLS-1:0]            outMem_wr_en;
  logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] outMem_wr_addr;
  logic                               active;
  logic                               done;

  modport master (
    input  start, num_row, num_col, base_addr,
    output outMem_wr_en, outMem_wr_addr, active, done
  );

  modport slave (
    output start, num_row, num_col, base_addr,
    input  outMem_wr_en, outMem_wr_addr, active, done
  );

endinterface

// File: rtl/master_output_drain_control_drain_column_decode.sv
// ---------------------------------------------------------------------------
// drain_column_decode
// Write enable/address decode for one output-memory column (index COL).
//   t_i         : drain step counter
//   num_row_i   : captured last row index
//   num_col_i   : captured last column index
//   base_addr_i : captured first write address
//   in_drain_i  : high while the FSM is draining
//   wr_en_o     : this column's write enable
//   wr_addr_o   : this column's write address, 0 when disabled
// Column COL writes at steps COL .. COL+num_row, i.e. it lags column 0 by
// COL cycles, matching the diagonal skew of the array outputs.
// ---------------------------------------------------------------------------
module drain_column_decode #(
  parameter int COL        = 0,
  parameter int ROW_W      = 4,
  parameter int COL_W      = 4,
  parameter int T_W        = 5,
  parameter int ADDR_WIDTH = 8
) (
  input  logic [T_W-1:0]        t_i,
  input  logic [ROW_W-1:0]      num_row_i,
  input  logic [COL_W-1:0]      num_col_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic                  in_drain_i,
  output logic                  wr_en_o,
  output logic [ADDR_WIDTH-1:0] wr_addr_o
);
  localparam logic [T_W-1:0] COL_T = T_W'(COL);

  // Range checks done with a borrow bit so that column 0 does not collapse
  // into a comparison against a constant.
  logic [T_W:0]   step_diff;
  logic [T_W:0]   col_diff;
  logic [T_W-1:0] offset;
  logic           started;
  logic           col_used;
  logic           in_rows;

  assign step_diff = {1'b0, t_i} - {1'b0, COL_T};
  assign col_diff  = {1'b0, T_W'(num_col_i)} - {1'b0, COL_T};
  assign offset    = step_diff[T_W-1:0];
  assign started   = ~step_diff[T_W];
  assign col_used  = ~col_diff[T_W];
  assign in_rows   = (offset <= T_W'(num_row_i));

  assign wr_en_o   = in_drain_i & col_used & started & in_rows;
  // Address wraps modulo 2^ADDR_WIDTH.
  assign wr_addr_o = wr_en_o ? (base_addr_i + ADDR_WIDTH'(offset)) : '0;

endmodule

// File: rtl/master_output_drain_control.sv
// ---------------------------------------------------------------------------
// master_output_drain_control
// Drains skewed systolic-array column outputs into the output memory.
//   clk   : clock, rising edge
//   reset : asynchronous active-low reset
//   bus   : master side of master_output_drain_control_if (job handshake,
//           per-column write enables/addresses, active/done status)
// The FSM, step counter and captured descriptor live here; each column's
// enable/address is decoded by its own drain_column_decode instance.
// ---------------------------------------------------------------------------
module master_output_drain_control
  import master_output_drain_control_pkg::*;
#(
  parameter int SYS_ARR_ROWS = 16,
  parameter int SYS_ARR_COLS = 16,
  parameter int ADDR_WIDTH   = 8
) (
  input logic                           clk,
  input logic                           reset,
  master_output_drain_control_if.master bus
);
  localparam int ROW_W = $clog2(SYS_ARR_ROWS);
  localparam int COL_W = $clog2(SYS_ARR_COLS);
  // Wide enough for num_row + num_col.
  localparam int T_W   = ((ROW_W > COL_W) ? ROW_W : COL_W) + 1;

  drain_state_e          state_q;
  logic [T_W-1:0]        t_q;
  logic [T_W-1:0]        t_d;
  logic [T_W-1:0]        last_step;
  logic [ROW_W-1:0]      num_row_q;
  logic [COL_W-1:0]      num_col_q;
  logic [ADDR_WIDTH-1:0] base_addr_q;
  logic                  active_q;
  logic                  done_q;

  assign t_d       = t_q + 1'b1;
  assign last_step = T_W'(num_row_q) + T_W'(num_col_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      t_q         <= '0;
      num_row_q   <= '0;
      num_col_q   <= '0;
      base_addr_q <= '0;
      active_q    <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            num_row_q   <= bus.num_row;
            num_col_q   <= bus.num_col;
            base_addr_q <= bus.base_addr;
            t_q         <= '0;
            state_q     <= ST_DRAIN;
            active_q    <= 1'b1;
          end
        end
        ST_DRAIN: begin
          if (t_q == last_step) begin
            state_q  <= ST_DONE;
            active_q <= 1'b0;
            done_q   <= 1'b1;
          end else begin
            t_q <= t_d;
          end
        end
        ST_DONE: begin
          // start is not sampled here, so a request now is dropped.
          state_q <= ST_IDLE;
          done_q  <= 1'b0;
        end
        default: begin
          state_q  <= ST_IDLE;
          active_q <= 1'b0;
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  logic [SYS_ARR_COLS-1:0]            col_en;
  logic [SYS_ARR_COLS*ADDR_WIDTH-1:0] col_addr;

  for (genvar gi = 0; gi < SYS_ARR_COLS; gi++) begin : g_col
    localparam int LO = col_slice_lo(gi, ADDR_WIDTH);
    drain_column_decode #(
      .COL       (gi),
      .ROW_W     (ROW_W),
      .COL_W     (COL_W),
      .T_W       (T_W),
      .ADDR_WIDTH(ADDR_WIDTH)
    ) u_decode (
      .t_i        (t_q),
      .num_row_i  (num_row_q),
      .num_col_i  (num_col_q),
      .base_addr_i(base_addr_q),
      .in_drain_i (active_q),
      .wr_en_o    (col_en[gi]),
      .wr_addr_o  (col_addr[LO +: ADDR_WIDTH])
    );
  end

  assign bus.outMem_wr_en   = col_en;
  assign bus.outMem_wr_addr = col_addr;
  assign bus.active         = active_q;
  assign bus.done           = done_q;

endmodule

// File: doc/master_output_drain_control.md
# master_output_drain_control

Drain master for the systolic array's result side. It collects the skewed column outputs of the array and writes them into the output memory: one write port per column, each with its own enable and address. It takes the same start/done handshake and `num_row`/`num_col`/`base_addr` job descriptor as the weight fill master, and runs the mirror-image schedule: array to memory instead of memory to array.

## Interface

Parameters:

- `SYS_ARR_ROWS`, 16: systolic array rows.
- `SYS_ARR_COLS`, 16: systolic array columns, and the number of output memory write ports.
- `ADDR_WIDTH`, 8: output memory address width.

Ports:

- `clk`  in  1  single clock; all state is on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle job request; sampled only in IDLE.
- `num_row`  in  $clog2(SYS_ARR_ROWS)  last row index; rows written = `num_row`+1.
- `num_col`  in  $clog2(SYS_ARR_COLS)  last column index; columns written = `num_col`+1.
- `base_addr`  in  ADDR_WIDTH  first write address for every column.
- `outMem_wr_en`  out  SYS_ARR_COLS  per-column write enable; bit c is column c.
- `outMem_wr_addr`  out  SYS_ARR_COLS*ADDR_WIDTH  per-column address; slice [c*ADDR_WIDTH +: ADDR_WIDTH] is column c.
- `active`  out  1  high while in DRAIN.
- `done`  out  1  one-cycle pulse when the job is complete.

## Operation

- States and transitions:
  - IDLE → DRAIN on `start`.
  - DRAIN → DONE after the last scheduled write.
  - DONE → IDLE unconditionally, one cycle later.
- On the `start` edge:
  - Capture `num_row`, `num_col` and `base_addr` into registers.
  - Clear the step counter `t`.
  - Later input changes do not affect the running job.
- DRAIN schedule:
  - `t` counts 0 .. `num_row`+`num_col`, one step per cycle.
  - Column c is enabled when c ≤ `num_col` and c ≤ t ≤ c+`num_row`.
  - This is the diagonal skew of the array outputs: column c lags column 0 by c cycles.
- Address of column c at step t is `base_addr` + (t − c), truncated to ADDR_WIDTH bits (wraps modulo 2^ADDR_WIDTH).
- When column c is disabled, its address slice drives 0.
- Columns above `num_col` never assert their enable.
- DRAIN lasts exactly `num_row`+`num_col`+1 cycles.
- `done` is high only in DONE. `active` is high only in DRAIN.
- `start` in DRAIN or DONE is ignored; it is not queued.

## Timing

- Reset values: state IDLE, `t`=0, captured registers 0. All outputs are 0: `outMem_wr_en`, `outMem_wr_addr`, `active` and `done`.
- Cycle numbering: cycle 1 is the first cycle after the edge that samples `start`.
  - t = cycle − 1.
  - `outMem_wr_en[0]` is high in cycle 1.
  - `active` is high in cycles 1 .. `num_row`+`num_col`+1.
  - `done` is high in cycle `num_row`+`num_col`+2.
- Outputs decode combinationally from the registered state, `t` and the captured descriptor only. There is no combinational path from `start` or any other input.
- Back-to-back jobs: the earliest accepted `start` is in the cycle after DONE, i.e. the first IDLE cycle.
- Reset asserted mid-job: all outputs go to 0 immediately (asynchronous), the FSM returns to IDLE and the job is abandoned. No `done` is issued for it.
- Degenerate job `num_row`=`num_col`=0: a single write on column 0 in cycle 1, then `done` in cycle 2.

## Structure

- Shared package holds:
  - the FSM state encoding (IDLE, DRAIN, DONE);
  - the port-slice helper constant for the per-column `ADDR_WIDTH` packing, which it shares with the weight fill master.
- One sub-module, `drain_column_decode`:
  - instantiated SYS_ARR_COLS times via generate, with column index c as a parameter;
  - inputs: `t`, the captured `num_row`, `num_col` and `base_addr`, and the in-DRAIN flag;
  - outputs: that column's enable and address.
- The top level holds the FSM, the step counter and the descriptor registers.

## Test plan

All scenarios use default parameters (16×16 array, ADDR_WIDTH 8).

1. **Reset:** hold `reset`=0 for 2 cycles, then release → all outputs 0, no `done`, `active`=0.
2. **Full job** (`num_row`=15, `num_col`=15, `base_addr`=12, `start` pulse):
   - `outMem_wr_en[0]` high in cycles 1–16 with addresses 12..27;
   - `outMem_wr_en[15]` high in cycles 16–31 with addresses 12..27;
   - `active` high in cycles 1–31; `done` pulses in cycle 32.
3. **Partial and wrap** (`num_row`=3, `num_col`=1, `base_addr`=254):
   - column 0 writes 254, 255, 0, 1 in cycles 1–4;
   - column 1 writes the same addresses in cycles 2–5;
   - bits 2–15 stay 0; `done` in cycle 6.
4. **Busy start:** pulse `start` in cycle 5 of scenario 2 → ignored; schedule and `done` timing unchanged. A new `start` in cycle 33 is accepted.
5. **Mid-job reset:** assert `reset`=0 in cycle 8 of scenario 2 → outputs 0 in that cycle and FSM in IDLE. No `done` follows. A subsequent `start` runs a clean job from t=0.
6. **Minimal job** (`num_row`=0, `num_col`=0, `base_addr`=7) → `outMem_wr_en`=16'h0001 with address 7 in cycle 1, `done` in cycle 2, then IDLE.
